// File: rtl/search_template_buf.sv
// Template window buffer for the correlation scorer.
// It captures a SEARCH_H_RES x SEARCH_V_RES window from the camera pixel
// stream at a programmable frame origin and stores it in on-chip RAM.
// Once loaded, it serves (X,Y) reads with one cycle of latency.
module search_template_buf #(
  parameter int SEARCH_H_RES = 64,
  parameter int SEARCH_V_RES = 48,
  parameter int FRAME_H_RES  = 640,
  parameter int FRAME_V_RES  = 480
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iCapture,
  input  logic [12:0] iXorig,
  input  logic [12:0] iYorig,
  input  logic        iFrameStart,
  input  logic        iDVAL,
  input  logic [9:0]  iPixel,
  input  logic [12:0] iX_read,
  input  logic [12:0] iY_read,
  output logic [9:0]  oReading,
  output logic        oReady,
  output logic        oBusy,
  output logic        oErr
);

  localparam int DEPTH = SEARCH_H_RES * SEARCH_V_RES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_READY} state_e;

  state_e      state_q, state_d;
  logic [12:0] fx_q, fx_d, fy_q, fy_d;
  logic [12:0] xorig_q, xorig_d, yorig_q, yorig_d;
  logic        err_q, err_d;
  logic        rd_valid_q, rd_valid_d;
  logic [9:0]  rd_data_q;
  logic [9:0]  mem [DEPTH];

  logic          pix_valid;
  logic          in_window;
  logic          origin_ok;
  logic          wr_en;
  logic          last_write;
  logic [25:0]   wr_addr_full;
  logic [AW-1:0] wr_addr;
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;

  // Frame position counters: a frame start clears them and takes priority over a coincident pixel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    fx_d = fx_q;
    fy_d = fy_q;
    if (iFrameStart) begin
      fx_d = '0;
      fy_d = '0;
    end else if (iDVAL) begin
      if (fx_q == 13'(FRAME_H_RES - 1)) begin
        fx_d = '0;
        if (fy_q != 13'(FRAME_V_RES - 1)) fy_d = fy_q + 13'd1;
      end else begin
        fx_d = fx_q + 13'd1;
      end
    end
  end

  // Capture datapath: window test, write address and detection of the final template word.
  always_comb begin
    pix_valid    = iDVAL && !iFrameStart;
    in_window    = (fx_q >= xorig_q) && (14'(fx_q) < 14'(xorig_q) + 14'(SEARCH_H_RES)) &&
                   (fy_q >= yorig_q) && (14'(fy_q) < 14'(yorig_q) + 14'(SEARCH_V_RES));
    wr_addr_full = 26'(fy_q - yorig_q) * 26'(SEARCH_H_RES) + 26'(fx_q - xorig_q);
    wr_addr      = wr_addr_full[AW-1:0];
    wr_en        = (state_q == S_CAPTURE) && pix_valid && in_window;
    last_write   = wr_en && (wr_addr_full == 26'(DEPTH - 1));
    origin_ok    = (14'(iXorig) + 14'(SEARCH_H_RES) <= 14'(FRAME_H_RES)) &&
                   (14'(iYorig) + 14'(SEARCH_V_RES) <= 14'(FRAME_V_RES));
  end

  // Control FSM: accept or reject capture requests, wait for a frame boundary, fill the RAM.
  always_comb begin
    state_d = state_q;
    xorig_d = xorig_q;
    yorig_d = yorig_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_READY: begin
        if (iCapture) begin
          if (origin_ok) begin
            xorig_d = iXorig;
            yorig_d = iYorig;
            state_d = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (iFrameStart) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A frame start before completion clears the counters, so the capture re-arms on
        // that boundary and restarts with the frame that is just beginning.
        if (last_write) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read port: range check on the raw coordinates, reads masked unless a template is loaded.
  always_comb begin
    rd_in_range = (iX_read < 13'(SEARCH_H_RES)) && (iY_read < 13'(SEARCH_V_RES));
    rd_addr     = rd_in_range ? AW'(26'(iY_read) * 26'(SEARCH_H_RES) + 26'(iX_read)) : '0;
    rd_valid_d  = (state_q == S_READY) && rd_in_range;
  end

  // Control and counter registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      fx_q       <= '0;
      fy_q       <= '0;
      xorig_q    <= '0;
      yorig_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      xorig_q    <= xorig_d;
      yorig_q    <= yorig_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Template RAM write port.
  always_ff @(posedge iCLK) begin
    // NOTE: the RAM and its read register are not reset so they map onto block RAM; rd_valid_q masks stale data.
    if (wr_en) mem[wr_addr] <= iPixel;
  end

  // Template RAM registered read port.
  always_ff @(posedge iCLK) begin
    rd_data_q <= mem[rd_addr];
  end

  assign oReading = rd_valid_q ? rd_data_q : '0;
  assign oReady   = (state_q == S_READY);
  assign oBusy    = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign oErr     = err_q;

endmodule

// File: tb/tb_search_template_buf.sv
// Directed self-checking bench for search_template_buf on a small 8x6 frame
// with a 4x3 template. Frame pixel value is fy*8+fx.
module tb_search_template_buf;

  localparam int SH = 4;
  localparam int SV = 3;
  localparam int FH = 8;
  localparam int FV = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture;
  logic [12:0] xorig, yorig, x_read, y_read;
  logic        frame_start, dval;
  logic [9:0]  pixel;
  logic [9:0]  reading;
  logic        ready, busy, err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  search_template_buf #(
    .SEARCH_H_RES(SH), .SEARCH_V_RES(SV), .FRAME_H_RES(FH), .FRAME_V_RES(FV)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iCapture(capture), .iXorig(xorig), .iYorig(yorig),
    .iFrameStart(frame_start), .iDVAL(dval), .iPixel(pixel),
    .iX_read(x_read), .iY_read(y_read),
    .oReading(reading), .oReady(ready), .oBusy(busy), .oErr(err)
  );

  // Advance one clock edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse iFrameStart (optionally with a coincident junk pixel), then stream n_pix pixels.
  // ready_idx is the index of the pixel whose edge first showed oReady=1, or -1.
  task automatic drive_frame(input int n_pix, input bit coincide, output int ready_idx);
    ready_idx   = -1;
    frame_start = 1'b1;
    dval        = coincide;
    pixel       = coincide ? 10'd999 : 10'd0;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < n_pix; i++) begin
      dval  = 1'b1;
      pixel = 10'((i / FH) * FH + (i % FH));
      step();
      if (ready && ready_idx < 0) ready_idx = i;
    end
    dval  = 1'b0;
    pixel = '0;
  endtask

  task automatic do_read(input int x, input int y, output logic [9:0] val);
    x_read = 13'(x);
    y_read = 13'(y);
    step();
    val = reading;
  endtask

  task automatic request(input int x, input int y);
    capture = 1'b1;
    xorig   = 13'(x);
    yorig   = 13'(y);
    step();
    capture = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] v;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    // Start a capture and get into the middle of it.
    request(0, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    dval = 1'b1; pixel = 10'd0; step();
    pixel = 10'd1; step();
    dval = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL busy_mid_capture: got %b expected 1", busy); else passed++;
    // Reset held three cycles mid-capture.
    rst_n = 1'b0;
    x_read = 13'd0; y_read = 13'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({reading, ready, busy, err} !== 13'd0)
        $display("FAIL outputs_in_reset cycle %0d: got reading=%0d ready=%b busy=%b err=%b expected all 0",
                 c, reading, ready, busy, err);
      else passed++;
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({ready, busy, err} !== 3'b000)
      $display("FAIL idle_after_reset: got ready=%b busy=%b err=%b expected 000", ready, busy, err);
    else passed++;
    do_read(0, 0, v);
    total++;
    if (v !== 10'd0 || ready !== 1'b0)
      $display("FAIL read_unloaded: got reading=%0d ready=%b expected 0 and 0", v, ready);
    else passed++;
  endtask

  task automatic test_load();
    int idx;
    logic [9:0] v;
    request(2, 1);
    total++;
    if (busy !== 1'b1 || ready !== 1'b0 || err !== 1'b0)
      $display("FAIL busy_after_capture: got busy=%b ready=%b err=%b expected 1 0 0", busy, ready, err);
    else passed++;
    drive_frame(FH * FV, 1'b0, idx);
    total++; if (idx !== 29) $display("FAIL ready_rise_pixel: got %0d expected 29", idx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL busy_after_load: got %b expected 0", busy); else passed++;
    do_read(0, 0, v);
    total++; if (v !== 10'd10) $display("FAIL read_0_0: got %0d expected 10", v); else passed++;
    do_read(3, 2, v);
    total++; if (v !== 10'd29) $display("FAIL read_3_2: got %0d expected 29", v); else passed++;
  endtask

  task automatic test_read_bounds();
    logic [9:0] v1, v2;
    do_read(4, 0, v1);
    total++; if (v1 !== 10'd0) $display("FAIL read_x_edge: got %0d expected 0", v1); else passed++;
    do_read(0, 3, v1);
    total++; if (v1 !== 10'd0) $display("FAIL read_y_edge: got %0d expected 0", v1); else passed++;
    do_read(1, 0, v1);
    do_read(2, 0, v2);
    total++; if (v1 !== 10'd11) $display("FAIL read_seq_first: got %0d expected 11", v1); else passed++;
    total++; if (v2 !== 10'd12) $display("FAIL read_seq_second: got %0d expected 12", v2); else passed++;
  endtask

  task automatic test_err();
    logic [9:0] v;
    request(5, 0);
    total++;
    if (err !== 1'b1 || ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL err_x_pulse: got err=%b ready=%b busy=%b expected 1 1 0", err, ready, busy);
    else passed++;
    step();
    total++;
    if (err !== 1'b0 || ready !== 1'b1)
      $display("FAIL err_x_one_cycle: got err=%b ready=%b expected 0 1", err, ready);
    else passed++;
    request(0, 4);
    total++; if (err !== 1'b1) $display("FAIL err_y_pulse: got %b expected 1", err); else passed++;
    step();
    total++; if (err !== 1'b0) $display("FAIL err_y_one_cycle: got %b expected 0", err); else passed++;
    do_read(0, 0, v);
    total++; if (v !== 10'd10) $display("FAIL read_after_err: got %0d expected 10", v); else passed++;
  endtask

  task automatic test_truncate();
    int idx;
    logic [9:0] v;
    request(0, 0);
    total++;
    if (ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL ready_drop_on_recapture: got ready=%b busy=%b expected 0 1", ready, busy);
    else passed++;
    drive_frame(10, 1'b0, idx);
    total++; if (idx !== -1) $display("FAIL truncated_no_ready: got %0d expected -1", idx); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL busy_after_truncate: got %b expected 1", busy); else passed++;
    drive_frame(FH * FV, 1'b0, idx);
    total++; if (idx !== 19) $display("FAIL restart_ready_pixel: got %0d expected 19", idx); else passed++;
    do_read(3, 2, v);
    total++; if (v !== 10'd19) $display("FAIL restart_read_3_2: got %0d expected 19", v); else passed++;
    do_read(1, 1, v);
    total++; if (v !== 10'd9) $display("FAIL restart_read_1_1: got %0d expected 9", v); else passed++;
  endtask

  task automatic test_coincide();
    int idx;
    logic [9:0] v;
    // Origin (4,3) sits exactly on the right and bottom frame edges and must be accepted.
    request(4, 3);
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || ready !== 1'b0)
      $display("FAIL edge_origin_accept: got err=%b busy=%b ready=%b expected 0 1 0", err, busy, ready);
    else passed++;
    // A second (out-of-range) request while armed is ignored silently.
    request(5, 0);
    total++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL capture_in_arm_ignored: got err=%b busy=%b expected 0 1", err, busy);
    else passed++;
    step();
    total++; if (err !== 1'b0) $display("FAIL no_late_err: got %b expected 0", err); else passed++;
    drive_frame(FH * FV, 1'b1, idx);
    total++; if (idx !== 47) $display("FAIL coincide_ready_pixel: got %0d expected 47", idx); else passed++;
    do_read(0, 0, v);
    total++; if (v !== 10'd28) $display("FAIL coincide_read_0_0: got %0d expected 28", v); else passed++;
    do_read(3, 2, v);
    total++; if (v !== 10'd47) $display("FAIL coincide_read_3_2: got %0d expected 47", v); else passed++;
    do_read(1, 1, v);
    total++; if (v !== 10'd37) $display("FAIL coincide_read_1_1: got %0d expected 37", v); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; capture = 1'b0; xorig = '0; yorig = '0;
    x_read = '0; y_read = '0; frame_start = 1'b0; dval = 1'b0; pixel = '0;
    test_reset();
    test_load();
    test_read_bounds();
    test_err();
    test_truncate();
    test_coincide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
